// File: rtl/pcap_pkg.sv
// Shared types for the capture ingress path: packet header layout, scheduler
// states and the byte-to-word conversion used when reserving buffer space.
package pcap_pkg;

    localparam int PACKET_HEADER_T_WIDTH = 32;
    localparam int MAX_PACKET_LEN        = 1518;

    typedef struct packed {
        logic [15:0] interface_id;
        logic [15:0] packet_length;
    } packet_header_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } sched_state_t;

    // 17-bit sum keeps len=65535 from wrapping before the shift.
    function automatic logic [14:0] len_to_words(input logic [15:0] len);
        return 15'((17'(len) + 17'd3) >> 2);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found searching upward from the interface after last_grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [N-1:0]         gnt
);

    localparam int IW = $clog2(N);

    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last_grant) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcap_ingress_scheduler.sv
// Ingress scheduler: picks one interface at a time round-robin, reserves buffer
// space, emits a header word and then streams that interface's payload words.
module pcap_ingress_scheduler
    import pcap_pkg::*;
#(
    parameter int N_IFACE = 4,
    parameter int MAX_LEN = MAX_PACKET_LEN
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_IFACE-1:0]                     req_valid,
    input  logic [16*N_IFACE-1:0]                  req_len,
    output logic [N_IFACE-1:0]                     req_ready,
    input  logic [PACKET_HEADER_T_WIDTH*N_IFACE-1:0] in_data,
    input  logic [N_IFACE-1:0]                     in_valid,
    output logic [N_IFACE-1:0]                     in_ready,
    output logic [PACKET_HEADER_T_WIDTH-1:0]       out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_sop,
    output logic                                   out_eop,
    input  logic [15:0]                            buf_free,
    output logic                                   drop_pulse,
    output logic                                   busy
);

    localparam int          IW        = $clog2(N_IFACE);
    localparam int          DW        = PACKET_HEADER_T_WIDTH;
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    sched_state_t  state_q, state_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [IW-1:0] g_q, g_d;
    logic [15:0]   len_q, len_d;
    logic [14:0]   words_q, words_d;
    logic [14:0]   rem_q, rem_d;

    logic [N_IFACE-1:0] gnt;
    logic [IW-1:0]      sel_idx;
    logic [15:0]        sel_len;
    logic [14:0]        sel_words;
    logic               sel_any, sel_drop, sel_fit;
    logic [DW-1:0]      g_data;
    logic               g_valid;
    packet_header_t     hdr;

    rr_arbiter #(.N(N_IFACE)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    always_comb begin
        sel_len = '0;
        sel_idx = '0;
        g_data  = '0;
        g_valid = 1'b0;
        for (int i = 0; i < N_IFACE; i++) begin
            if (gnt[i]) begin
                sel_len = req_len[i*16 +: 16];
                sel_idx = IW'(i);
            end
            if (g_q == IW'(i)) begin
                g_data  = in_data[i*DW +: DW];
                g_valid = in_valid[i];
            end
        end
    end

    assign sel_words = len_to_words(sel_len);
    assign sel_any   = |gnt;
    assign sel_drop  = sel_any && ((sel_len == 16'd0) || (sel_len > MAX_LEN_W));
    // One extra word is reserved for the header.
    assign sel_fit   = sel_any && !sel_drop && (17'(buf_free) >= (17'(sel_words) + 17'd1));

    always_comb begin
        hdr.interface_id  = 16'(g_q);
        hdr.packet_length = len_q;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        g_d          = g_q;
        len_d        = len_q;
        words_d      = words_q;
        rem_d        = rem_q;
        req_ready    = '0;
        in_ready     = '0;
        out_data     = '0;
        out_valid    = 1'b0;
        out_sop      = 1'b0;
        out_eop      = 1'b0;
        drop_pulse   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Requests are not consumed while reset is held.
                if (!rst) begin
                    if (sel_drop) begin
                        req_ready    = gnt;
                        drop_pulse   = 1'b1;
                        last_grant_d = sel_idx;
                    end else if (sel_fit) begin
                        req_ready = gnt;
                        g_d       = sel_idx;
                        len_d     = sel_len;
                        words_d   = sel_words;
                        state_d   = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                out_valid = 1'b1;
                out_sop   = 1'b1;
                out_data  = hdr;
                if (out_ready) begin
                    rem_d   = words_q;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                out_valid     = g_valid;
                out_data      = g_data;
                in_ready[g_q] = out_ready;
                out_eop       = (rem_q == 15'd1);
                if (g_valid && out_ready) begin
                    rem_d = rem_q - 15'd1;
                    if (rem_q == 15'd1) begin
                        state_d      = ST_IDLE;
                        last_grant_d = g_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IW'(N_IFACE - 1);
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge clk) begin
        g_q     <= g_d;
        len_q   <= len_d;
        words_q <= words_d;
        rem_q   <= rem_d;
    end

endmodule

// File: tb/tb_pcap_ingress_scheduler.sv
// Directed bench for pcap_ingress_scheduler: a packet table plus hand-written
// sequences for round-robin order, buffer backpressure, stalls and reset.
module tb_pcap_ingress_scheduler;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [16*N-1:0] req_len;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [31:0]     out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_sop;
    logic            out_eop;
    logic [15:0]     buf_free;
    logic            drop_pulse;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pcap_ingress_scheduler #(.N_IFACE(N), .MAX_LEN(1518)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .buf_free   (buf_free),
        .drop_pulse (drop_pulse),
        .busy       (busy)
    );

    typedef struct {
        int          ifc;
        int          len;
        int          bfree;
        bit          drop;
        logic [31:0] hdr;
        int          words;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input int ifc, input int w);
        return 32'hD000_0000 | (32'(ifc) << 16) | 32'(w);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_sop"}, 32'(out_sop), 32'd0);
        chk({tag, "_out_eop"}, 32'(out_eop), 32'd0);
        chk({tag, "_drop_pulse"}, 32'(drop_pulse), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Starts in the IDLE cycle where the request for ifc is already presented.
    task automatic expect_pkt(input int ifc, input bit drop, input logic [31:0] hdr, input int words);
        #1;
        chk("grant_req_ready", 32'(req_ready), 32'(1 << ifc));
        chk("grant_drop_pulse", 32'(drop_pulse), 32'(drop));
        chk("grant_out_valid", 32'(out_valid), 32'd0);
        tick();
        req_valid[ifc] = 1'b0;
        if (drop) begin
            chk("drop_busy", 32'(busy), 32'd0);
            chk("drop_out_valid", 32'(out_valid), 32'd0);
            return;
        end
        chk("hdr_valid", 32'(out_valid), 32'd1);
        chk("hdr_sop", 32'(out_sop), 32'd1);
        chk("hdr_eop", 32'(out_eop), 32'd0);
        chk("hdr_data", out_data, hdr);
        chk("hdr_busy", 32'(busy), 32'd1);
        chk("hdr_req_ready", 32'(req_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        for (int w = 0; w < words; w++) begin
            in_valid[ifc] = 1'b1;
            in_data[ifc*32 +: 32] = pat(ifc, w);
            #1;
            chk("data_valid", 32'(out_valid), 32'd1);
            chk("data_word", out_data, pat(ifc, w));
            chk("data_sop", 32'(out_sop), 32'd0);
            chk("data_eop", 32'(out_eop), 32'(w == words - 1));
            chk("data_in_ready", 32'(in_ready), 32'(1 << ifc));
            tick();
        end
        in_valid = '0;
        #1;
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int widx;
        int guard;

        vecs[0] = '{ifc: 0, len: 8,    bfree: 100, drop: 1'b0, hdr: 32'h0000_0008, words: 2};
        vecs[1] = '{ifc: 2, len: 0,    bfree: 100, drop: 1'b1, hdr: 32'h0,         words: 0};
        vecs[2] = '{ifc: 2, len: 1519, bfree: 100, drop: 1'b1, hdr: 32'h0,         words: 0};
        vecs[3] = '{ifc: 3, len: 1518, bfree: 381, drop: 1'b0, hdr: 32'h0003_05EE, words: 380};
        vecs[4] = '{ifc: 1, len: 1,    bfree: 100, drop: 1'b0, hdr: 32'h0001_0001, words: 1};
        vecs[5] = '{ifc: 0, len: 5,    bfree: 100, drop: 1'b0, hdr: 32'h0000_0005, words: 2};

        rst       = 1'b1;
        req_valid = '0;
        req_len   = '0;
        in_data   = {N{32'hBAD0_0000}};
        in_valid  = '0;
        out_ready = 1'b1;
        buf_free  = 16'd100;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk_all_zero("post_reset");

        // Packet table: one requester at a time.
        foreach (vecs[v]) begin
            buf_free = 16'(vecs[v].bfree);
            req_len[vecs[v].ifc*16 +: 16] = 16'(vecs[v].len);
            req_valid[vecs[v].ifc] = 1'b1;
            expect_pkt(vecs[v].ifc, vecs[v].drop, vecs[v].hdr, vecs[v].words);
        end

        // Round robin: last grant was 0, so 1,2,3 follow in order.
        buf_free = 16'd100;
        for (int i = 1; i < 4; i++) req_len[i*16 +: 16] = 16'd4;
        req_valid = 4'b1110;
        expect_pkt(1, 1'b0, 32'h0001_0004, 1);
        expect_pkt(2, 1'b0, 32'h0002_0004, 1);
        expect_pkt(3, 1'b0, 32'h0003_0004, 1);

        // Insufficient space holds if0 and blocks if1 from bypassing.
        buf_free = 16'd10;
        req_len[0 +: 16]  = 16'd40;
        req_len[16 +: 16] = 16'd4;
        req_valid = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("nospace_req_ready", 32'(req_ready), 32'd0);
            chk("nospace_busy", 32'(busy), 32'd0);
            tick();
        end
        req_valid[1] = 1'b0;
        buf_free = 16'd11;
        expect_pkt(0, 1'b0, 32'h0000_0028, 10);

        // Header and data stalls on if1, len 13 -> 4 words.
        buf_free = 16'd100;
        req_len[16 +: 16] = 16'd13;
        req_valid[1] = 1'b1;
        #1;
        chk("stall_grant", 32'(req_ready), 32'b0010);
        out_ready = 1'b0;
        tick();
        req_valid[1] = 1'b0;
        chk("stall_hdr0", out_data, 32'h0001_000D);
        tick();
        chk("stall_hdr1", out_data, 32'h0001_000D);
        chk("stall_hdr_sop", 32'(out_sop), 32'd1);
        out_ready = 1'b1;
        tick();
        widx  = 0;
        guard = 0;
        while (widx < 4 && guard < 20) begin
            out_ready = (guard % 2 == 0);
            in_valid[1] = 1'b1;
            in_data[32 +: 32] = pat(1, widx);
            #1;
            chk("stall_data", out_data, pat(1, widx));
            chk("stall_eop", 32'(out_eop), 32'(widx == 3));
            chk("stall_in_ready", 32'(in_ready), 32'(out_ready) << 1);
            tick();
            if (out_ready) widx++;
            guard++;
        end
        in_valid = '0;
        out_ready = 1'b1;
        chk("stall_words", 32'(widx), 32'd4);
        chk("stall_cycles", 32'(guard), 32'd7);
        #1;
        chk("stall_end_busy", 32'(busy), 32'd0);

        // Reset after the 2nd data word of an if2 packet.
        req_len[32 +: 16] = 16'd16;
        req_valid[2] = 1'b1;
        #1;
        chk("rstmid_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid[2] = 1'b0;
        chk("rstmid_hdr", out_data, 32'h0002_0010);
        tick();
        for (int w = 0; w < 2; w++) begin
            in_valid[2] = 1'b1;
            in_data[64 +: 32] = pat(2, w);
            #1;
            chk("rstmid_data", out_data, pat(2, w));
            if (w == 1) rst = 1'b1;
            tick();
        end
        req_len[0 +: 16]  = 16'd4;
        req_len[48 +: 16] = 16'd4;
        req_valid = 4'b1001;
        #1;
        chk_all_zero("rstmid");
        rst = 1'b0;
        in_valid = '0;
        expect_pkt(0, 1'b0, 32'h0000_0004, 1);
        expect_pkt(3, 1'b0, 32'h0003_0004, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
